// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request and computes
// the next PC. It also owns the IF/ID pipeline register. A one-entry hold
// buffer catches a fetch that completes while ID is stalled. Requests that are
// still outstanding when a redirect or a reset arrives are tracked, so that
// their late responses are dropped.
module if_fetch_unit #(
    parameter int unsigned     WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] curr_pc,
    output logic [WORD-1:0] next_pc,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [WORD-1:0] redirect_pc_i,
    output logic            id_valid,
    output logic [WORD-1:0] id_instr,
    output logic [WORD-1:0] id_pc,
    output logic [WORD-1:0] id_pc_plus4
);

    localparam logic [WORD-1:0] PC_STEP = WORD'(4);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        KILL
    } state_t;

    state_t          state;
    logic            inflight;      // memory still owes a response
    logic            drop_pending;  // owed response belongs to a pre-reset request
    logic [WORD-1:0] hold_instr;
    logic [WORD-1:0] hold_pc;
    logic            fetch_done;
    logic            id_free;

    // A response is live data only in FETCH and only if it is not a leftover from before reset
    assign fetch_done  = (state == FETCH) && imem_rvalid && !drop_pending;
    assign id_free     = !id_valid || !stall_i;

    // Memory request, fetch address and IF/ID pc+4
    always_comb begin
        imem_req    = rst_n && (state == FETCH);
        imem_addr   = {curr_pc[WORD-1:2], 2'b00};
        id_pc_plus4 = id_pc + PC_STEP;
    end

    // Next PC selection: reset, then redirect, then fetch completion, else hold
    always_comb begin
        next_pc = curr_pc;
        if (!rst_n) begin
            next_pc = RESET_PC;
        end else if (redirect_i) begin
            next_pc = {redirect_pc_i[WORD-1:2], 2'b00};
        end else if (fetch_done) begin
            next_pc = curr_pc + PC_STEP;
        end
    end

    // Fetch FSM, IF/ID register, hold buffer and outstanding-request tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            id_valid     <= 1'b0;
            id_instr     <= '0;
            id_pc        <= '0;
            hold_instr   <= '0;
            hold_pc      <= '0;
            // Reset cannot cancel a request already at the memory; remember it
            // so its response is discarded after reset is released.
            inflight     <= inflight & ~imem_rvalid;
            drop_pending <= inflight & ~imem_rvalid;
        end else begin
            inflight <= (inflight | imem_req) & ~imem_rvalid;
            if (imem_rvalid) begin
                drop_pending <= 1'b0;
            end

            case (state)
                FETCH: begin
                    if (redirect_i) begin
                        id_valid <= 1'b0;
                        if (!imem_rvalid) begin
                            state <= KILL;
                        end
                    end else if (fetch_done) begin
                        if (id_free) begin
                            id_valid <= 1'b1;
                            id_instr <= imem_rdata;
                            id_pc    <= curr_pc;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= curr_pc;
                            state      <= HOLD;
                        end
                    end else if (!stall_i) begin
                        id_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect_i) begin
                        id_valid   <= 1'b0;
                        hold_instr <= '0;
                        hold_pc    <= '0;
                        state      <= FETCH;
                    end else if (!stall_i) begin
                        id_valid <= 1'b1;
                        id_instr <= hold_instr;
                        id_pc    <= hold_pc;
                        state    <= FETCH;
                    end
                end

                KILL: begin
                    if (redirect_i || !stall_i) begin
                        id_valid <= 1'b0;
                    end
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
